// File: rtl/fetch_pkg.sv
// Shared widths and the fetch buffer entry layout.
// Provides defaults for address, instruction and FIFO depth.
package fetch_pkg;

    localparam int FETCH_AW    = 8;
    localparam int FETCH_IW    = 16;
    localparam int FETCH_DEPTH = 4;

    typedef struct packed {
        logic [FETCH_IW-1:0] data;
        logic [FETCH_AW-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// First-word fall-through FIFO holding fetched words with their PC.
// Ports: push/wdata write, pop advances head, flush empties, rdata is head, count is occupancy.
module fetch_fifo #(
    parameter  int W     = 24,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    input  logic          flush,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the pc, issues memory reads, buffers tagged words.
// Ports: pc_in/pc_enable/pc_increment to pc, mem_* to imem, redirect_* from execute, instr_* to decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int AW    = FETCH_AW,
    parameter int IW    = FETCH_IW,
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] pc_in,
    output logic          pc_enable,
    output logic [AW-1:0] pc_increment,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [IW-1:0] mem_rdata,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_target,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [IW-1:0] instr_data,
    output logic [AW-1:0] instr_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]    count;
    logic             inflight;
    logic [AW-1:0]    tag;
    logic             credit;
    logic             issue;
    logic             push;
    logic             pop;
    logic [IW+AW-1:0] head;

    // Credit counts the in-flight read; a pop this cycle frees nothing yet.
    assign credit = ({1'b0, count} + {{CW{1'b0}}, inflight})
                    < (CW + 1)'(DEPTH);

    assign issue     = !reset && !redirect_valid && credit;
    assign mem_rd    = issue;
    assign mem_addr  = pc_in;
    assign pc_enable = !reset && (issue || redirect_valid);

    // The pc only adds, so a jump becomes target minus current, mod 2^AW.
    always_comb begin
        pc_increment = AW'(1);
        if (reset)
            pc_increment = '0;
        else if (redirect_valid)
            pc_increment = redirect_target - pc_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= 1'b0;
            tag      <= '0;
        end else begin
            inflight <= issue;
            if (issue) tag <= pc_in;
        end
    end

    assign instr_valid = (count != '0);
    assign push        = inflight && !redirect_valid;
    assign pop         = instr_valid && instr_ready && !redirect_valid;

    fetch_fifo #(
        .W     (IW + AW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata ({mem_rdata, tag}),
        .pop   (pop),
        .flush (redirect_valid),
        .rdata (head),
        .count (count)
    );

    assign {instr_data, instr_pc} = head;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly downstream of the program counter (pc).
- Reads pc_out and drives the pc's enable/increment inputs, so it alone controls PC advance.
- Issues synchronous reads to instruction memory and buffers returned words, tagged with their PC, in a small FIFO.
- Presents instructions to decode over a valid/ready handshake; supports redirect (jump) from execute.

Parameters:
- AW, 8, address/PC width; matches the pc block.
- IW, 16, instruction word width.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc_in  in  AW  current PC; connects to pc_out.
- pc_enable  out  1  connects to pc enable.
- pc_increment  out  AW  connects to pc increment.
- mem_rd  out  1  memory read strobe.
- mem_addr  out  AW  memory read address.
- mem_rdata  in  IW  read data, valid exactly 1 cycle after mem_rd.
- redirect_valid  in  1  jump request from execute.
- redirect_target  in  AW  jump target address.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decode accepts the head.
- instr_data  out  IW  head instruction word.
- instr_pc  out  AW  PC of the head instruction.

Behaviour:
- Reset (async): count=0, pointers=0, inflight=0, instr_valid=0. While reset is high, mem_rd=0, pc_enable=0, pc_increment=0.
- Credit rule: issue = !redirect_valid && (count + inflight < DEPTH).
  - Uses registered values only; a same-cycle pop gives no credit.
- Combinational outputs:
  - mem_rd = issue; mem_addr = pc_in.
  - pc_enable = issue | redirect_valid.
  - pc_increment = redirect_valid ? (redirect_target - pc_in) mod 2^AW : 1.
- Response path:
  - On issue, inflight<=1 and tag<=pc_in at the clock edge; otherwise inflight<=0.
  - Next cycle, if inflight and no redirect, {mem_rdata, tag} is written to the FIFO tail.
- Latency and throughput:
  - An address issued in cycle t appears at instr_valid in cycle t+2 (first-word fall-through).
  - Sustained rate is 1 instruction/cycle with instr_ready=1.
- Pop: a transfer occurs when instr_valid & instr_ready.
  - Simultaneous write and pop leaves count unchanged.
  - Overflow is impossible by credit; an underflow pop is impossible since instr_valid = (count != 0).
- Redirect takes precedence over issue, write and pop:
  - FIFO is cleared (count=0, pointers reset).
  - An in-flight response is discarded (inflight<=0, no write).
  - A handshake completing in the redirect cycle counts as delivered.
  - instr_valid is 0 in the following cycle.
  - The first post-redirect fetch issues the cycle after redirect (pc_in = target).
- Wrap-around: PC and tag arithmetic is mod 2^AW (0xFF+1 = 0x00); the increment subtraction wraps identically.
- Reset mid-operation: all buffered and in-flight data is lost. The fetch restarts from the pc's reset value once reset deasserts.

Decomposition:
- Package fetch_pkg: AW, IW and DEPTH defaults; FIFO entry struct {data[IW], pc[AW]}.
- Sub-module fetch_fifo:
  - Synchronous DEPTH-entry FIFO, first-word fall-through.
  - Ports: push, pop, flush, count.
  - Async active-high reset.
- fetch_unit holds the credit/issue logic, inflight tag and redirect arithmetic.

Test Plan:
- Free run: memory model returns {8'hA5, addr}, instr_ready=1, pc instantiated.
  -> After reset release, instr_valid rises on the 3rd edge.
  -> instr_pc = 00, 01, 02, ... one per cycle; instr_data = A500, A501, ...
- Backpressure: instr_ready=0 from reset release.
  -> count reaches 4 and pc_enable drops; pc_out holds 04.
  -> Raising instr_ready drains 00..03, then resumes with 04, in order, no loss or duplicate.
- Forward redirect at pc_in=03, target 0x80.
  -> pc_increment=0x7D, pc_out=0x80 next cycle.
  -> Tag 02 in-flight is dropped; FIFO is empty the following cycle.
  -> Next delivered instr_pc=0x80.
- Backward redirect at pc_in=0x10, target 0x02.
  -> pc_increment=0xF2; delivered sequence resumes 02, 03, ...
- Wrap: redirect to 0xFE, instr_ready=1.
  -> Delivered instr_pc = FE, FF, 00, 01 with matching data.
- Mid-operation reset with count=3.
  -> instr_valid, mem_rd and pc_enable go 0 immediately (before the next edge).
  -> After release, delivery restarts at instr_pc=00.
